// File: rtl/pb_pkg.sv
// ============================================================================
//  Module      : pb_pkg
//  Description : Shared FSM encoding, default constants and width helpers for
//                the push-button conditioning bank.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pb_pkg;

   typedef enum logic [1:0] {
      PB_IDLE = 2'd0,
      PB_HELD = 2'd1,
      PB_LONG = 2'd2
   } pb_state_e;

   localparam int PB_N_BTN_DEF         = 4;
   localparam int PB_DEB_CYCLES_DEF    = 16;
   localparam int PB_LONG_CYCLES_DEF   = 1000;
   localparam int PB_REPEAT_CYCLES_DEF = 200;
   localparam int PB_ACTIVE_LOW_DEF    = 0;
   localparam int PB_CNT_W_DEF         = 16;

   // Bits needed to hold 0 .. value-1 (never less than one bit).
   function automatic int pb_clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width++;
      return width;
   endfunction

   function automatic int pb_max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pushbutton_bank_if.sv
// ============================================================================
//  Module      : pushbutton_bank_if
//  Description : Button pins and conditioned event outputs of the bank.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pushbutton_bank_if #(
   parameter int N_BTN = pb_pkg::PB_N_BTN_DEF
);
   logic [N_BTN-1:0] pb_in;
   logic [N_BTN-1:0] pb_level;
   logic [N_BTN-1:0] press_pulse;
   logic [N_BTN-1:0] release_pulse;
   logic [N_BTN-1:0] long_pulse;
   logic             any_pressed;

   modport master (
      output pb_in,
      input  pb_level, press_pulse, release_pulse, long_pulse, any_pressed
   );

   modport slave (
      input  pb_in,
      output pb_level, press_pulse, release_pulse, long_pulse, any_pressed
   );
endinterface

`default_nettype wire

// File: rtl/pb_channel.sv
// ============================================================================
//  Module      : pb_channel
//  Description : One button channel: 2-FF synchroniser, debounce, press /
//                release pulses and IDLE/HELD/LONG long-press FSM.
//                Optional auto-repeat in LONG when PB_AUTOREPEAT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_channel
   import pb_pkg::*;
#(
   parameter int DEB_CYCLES    = PB_DEB_CYCLES_DEF,
   parameter int LONG_CYCLES   = PB_LONG_CYCLES_DEF,
`ifdef PB_AUTOREPEAT_EN
   parameter int REPEAT_CYCLES = PB_REPEAT_CYCLES_DEF,
`endif
   parameter int ACTIVE_LOW    = PB_ACTIVE_LOW_DEF,
   parameter int CNT_W         = PB_CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb_i,
   output logic level_o,
   output logic level_d_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int DEB_W = pb_clog2(DEB_CYCLES);

   logic             pb_raw;
   logic             sync1_q, sync2_q;
   logic [DEB_W-1:0] deb_cnt_q;
   logic             level_q, level_d;
   logic             press_q, release_q, long_q;
   pb_state_e        state_q;
   logic [CNT_W-1:0] hold_cnt_q;
   logic             mismatch, deb_done, rise, fall, rep_fire;

   assign pb_raw   = (ACTIVE_LOW != 0) ? ~pb_i : pb_i;
   assign mismatch = (sync2_q != level_q);
   assign deb_done = mismatch && (deb_cnt_q == DEB_W'(DEB_CYCLES - 1));
   assign rise     = deb_done && !level_q;
   assign fall     = deb_done &&  level_q;
   assign level_d  = level_q ^ deb_done;

`ifdef PB_AUTOREPEAT_EN
   logic [CNT_W-1:0] rep_cnt_q;

   // A release on the same edge suppresses the repeat pulse.
   assign rep_fire = (state_q == PB_LONG) && !fall &&
                     (rep_cnt_q == CNT_W'(REPEAT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt_q <= '0;
      end else if (state_q != PB_LONG || fall || rep_fire) begin
         rep_cnt_q <= '0;
      end else begin
         rep_cnt_q <= rep_cnt_q + CNT_W'(1);
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         deb_cnt_q  <= '0;
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
         state_q    <= PB_IDLE;
         hold_cnt_q <= '0;
      end else begin
         sync1_q   <= pb_raw;
         sync2_q   <= sync1_q;
         level_q   <= level_d;
         deb_cnt_q <= (mismatch && !deb_done) ? deb_cnt_q + DEB_W'(1) : '0;
         press_q   <= rise | rep_fire;
         release_q <= fall;
         long_q    <= 1'b0;

         // Release has priority over reaching the long-press terminal count.
         if (fall) begin
            state_q    <= PB_IDLE;
            hold_cnt_q <= '0;
         end else begin
            case (state_q)
               PB_IDLE: begin
                  if (rise) begin
                     state_q    <= PB_HELD;
                     hold_cnt_q <= '0;
                  end
               end
               PB_HELD: begin
                  if (hold_cnt_q == CNT_W'(LONG_CYCLES - 1)) begin
                     long_q  <= 1'b1;
                     state_q <= PB_LONG;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                  end
               end
               PB_LONG: begin
                  hold_cnt_q <= hold_cnt_q;
               end
               default: begin
                  state_q    <= PB_IDLE;
                  hold_cnt_q <= '0;
               end
            endcase
         end
      end
   end

   assign level_o   = level_q;
   assign level_d_o = level_d;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;

endmodule

`default_nettype wire

// File: rtl/pushbutton_bank.sv
// ============================================================================
//  Module      : pushbutton_bank
//  Description : N_BTN independent push-button conditioning channels plus a
//                registered any-pressed flag. Auto-repeat: PB_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pushbutton_bank
   import pb_pkg::*;
#(
   parameter int N_BTN         = PB_N_BTN_DEF,
   parameter int DEB_CYCLES    = PB_DEB_CYCLES_DEF,
   parameter int LONG_CYCLES   = PB_LONG_CYCLES_DEF,
   parameter int REPEAT_CYCLES = PB_REPEAT_CYCLES_DEF,
   parameter int ACTIVE_LOW    = PB_ACTIVE_LOW_DEF,
   parameter int CNT_W         = PB_CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pushbutton_bank_if.slave      bus
);

   logic [N_BTN-1:0] level_d;
   logic             any_pressed_q;

   if (DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES || REPEAT_CYCLES < 1 ||
       CNT_W < pb_clog2(pb_max3(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES) + 1))
   begin : g_param_check
      $error("pushbutton_bank: invalid parameter combination");
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      pb_channel #(
         .DEB_CYCLES   (DEB_CYCLES),
         .LONG_CYCLES  (LONG_CYCLES),
`ifdef PB_AUTOREPEAT_EN
         .REPEAT_CYCLES(REPEAT_CYCLES),
`endif
         .ACTIVE_LOW   (ACTIVE_LOW),
         .CNT_W        (CNT_W)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .pb_i      (bus.pb_in[i]),
         .level_o   (bus.pb_level[i]),
         .level_d_o (level_d[i]),
         .press_o   (bus.press_pulse[i]),
         .release_o (bus.release_pulse[i]),
         .long_o    (bus.long_pulse[i])
      );
   end

   // Registered from the next-state levels so it tracks pb_level exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_pressed_q <= 1'b0;
      end else begin
         any_pressed_q <= |level_d;
      end
   end

   assign bus.any_pressed = any_pressed_q;

endmodule

`default_nettype wire

// File: tb/tb_pushbutton_bank.sv
// ============================================================================
//  Module      : tb_pushbutton_bank
//  Description : Directed and randomized bench for pushbutton_bank with a
//                history-window reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pushbutton_bank;

   localparam int N    = 4;
   localparam int DEB  = 4;
   localparam int LONG = 20;
   localparam int REP  = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   pushbutton_bank_if #(.N_BTN(N)) bus ();

   pushbutton_bank #(
      .N_BTN(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG),
      .REPEAT_CYCLES(REP), .ACTIVE_LOW(0), .CNT_W(16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: level flips once the last DEB synchronised samples
   // (pin delayed by two edges) all disagree with it; long/repeat events are
   // derived from the age of the current press.
   bit [N-1:0]     m_level, m_press, m_release, m_long;
   bit             m_any;
   bit [DEB+1:0]   m_pins [N];
   int             m_t_press [N];
   int             m_cyc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_level   <= '0;
         m_press   <= '0;
         m_release <= '0;
         m_long    <= '0;
         m_any     <= 1'b0;
         m_cyc     <= 0;
         for (int c = 0; c < N; c++) begin
            m_pins[c]    <= '0;
            m_t_press[c] <= 0;
         end
      end else begin : model_step
         bit [N-1:0]   lv, pr, rl, lg;
         bit [DEB+1:0] hist;
         int           age;
         lv = m_level;
         pr = '0;
         rl = '0;
         lg = '0;
         for (int c = 0; c < N; c++) begin
            hist = {m_pins[c][DEB:0], bus.pb_in[c]};
            m_pins[c] <= hist;
            if (hist[DEB+1:2] == {DEB{~lv[c]}}) begin
               lv[c] = ~lv[c];
               if (lv[c]) begin
                  pr[c] = 1'b1;
                  m_t_press[c] <= m_cyc + 1;
               end else begin
                  rl[c] = 1'b1;
               end
            end else if (lv[c]) begin
               age = m_cyc + 1 - m_t_press[c];
               if (age == LONG) lg[c] = 1'b1;
`ifdef PB_AUTOREPEAT_EN
               if (age >= LONG + REP && (age - LONG) % REP == 0) pr[c] = 1'b1;
`endif
            end
         end
         m_level   <= lv;
         m_press   <= pr;
         m_release <= rl;
         m_long    <= lg;
         m_any     <= |lv;
         m_cyc     <= m_cyc + 1;
      end
   end

   logic [4*N:0] dut_vec, mod_vec;
   assign dut_vec = {bus.pb_level, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.any_pressed};
   assign mod_vec = {m_level, m_press, m_release, m_long, m_any};

   task automatic settle(input int n);
      bus.pb_in = '0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.pb_in = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (dut_vec !== '0) begin
         errors++;
         $display("FAIL reset_state: dut=%h expected=0", dut_vec);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== mod_vec) begin
            errors++;
            $display("FAIL reset_idle k=%0d: dut=%h model=%h", k, dut_vec, mod_vec);
         end
      end
   endtask

   task automatic test_clean_press();
      int first = -1;
      bus.pb_in = 4'b0001;
      for (int t = 1; t <= 10; t++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== mod_vec) begin
            errors++;
            $display("FAIL clean_press_model t=%0d: dut=%h model=%h", t, dut_vec, mod_vec);
         end
         if (first > 0 && t == first + 1) begin
            checks++;
            if (bus.press_pulse !== 4'b0000) begin
               errors++;
               $display("FAIL clean_press_width: press=%b expected=0000", bus.press_pulse);
            end
         end
         if (bus.press_pulse[0] && first < 0) begin
            first = t;
            checks++;
            if (bus.pb_level !== 4'b0001 || bus.press_pulse !== 4'b0001) begin
               errors++;
               $display("FAIL clean_press_level: level=%b press=%b expected=0001", bus.pb_level, bus.press_pulse);
            end
         end
      end
      checks++;
      if (first != 2 + DEB) begin
         errors++;
         $display("FAIL clean_press_latency: got=%0d expected=%0d", first, 2 + DEB);
      end
      settle(12);
   endtask

   task automatic test_bounce();
      int n_press = 0;
      int n_rel   = 0;
      int when    = -1;
      for (int k = 0; k < 42; k++) begin
         bus.pb_in[1] = (k >= 30) ? 1'b1 : ((k % 5) < 3);
         @(negedge clk);
         checks++;
         if (dut_vec !== mod_vec) begin
            errors++;
            $display("FAIL bounce_model t=%0d: dut=%h model=%h", k + 1, dut_vec, mod_vec);
         end
         if (bus.press_pulse[1]) begin
            n_press++;
            when = k + 1 - 30;
         end
         if (bus.release_pulse[1]) n_rel++;
      end
      checks++;
      if (n_press != 1 || when != 2 + DEB || n_rel != 0) begin
         errors++;
         $display("FAIL bounce_pulses: presses=%0d at=%0d releases=%0d expected 1 at %0d, 0", n_press, when, n_rel, 2 + DEB);
      end
      settle(12);
   endtask

   task automatic test_long_press();
      int t_p = -1, t_l = -1, t_r = -1, n_long = 0;
      for (int k = 0; k < 55; k++) begin
         bus.pb_in[2] = (k < 40);
         @(negedge clk);
         checks++;
         if (dut_vec !== mod_vec) begin
            errors++;
            $display("FAIL long_model t=%0d: dut=%h model=%h", k + 1, dut_vec, mod_vec);
         end
         if (bus.press_pulse[2] && t_p < 0) t_p = k + 1;
         if (bus.long_pulse[2]) begin
            n_long++;
            t_l = k + 1;
         end
         if (bus.release_pulse[2]) t_r = k + 1;
      end
      checks++;
      if (n_long != 1 || t_l - t_p != LONG) begin
         errors++;
         $display("FAIL long_pulse: count=%0d offset=%0d expected 1 at %0d", n_long, t_l - t_p, LONG);
      end
      checks++;
      if (t_r - 40 != 2 + DEB) begin
         errors++;
         $display("FAIL long_release: offset=%0d expected=%0d", t_r - 40, 2 + DEB);
      end
      settle(12);
   endtask

   task automatic test_short_press();
      int n_p = 0, n_r = 0, n_l = 0;
      for (int k = 0; k < 30; k++) begin
         bus.pb_in[0] = (k < 10);
         @(negedge clk);
         checks++;
         if (dut_vec !== mod_vec) begin
            errors++;
            $display("FAIL short_model t=%0d: dut=%h model=%h", k + 1, dut_vec, mod_vec);
         end
         n_p += int'(bus.press_pulse[0]);
         n_r += int'(bus.release_pulse[0]);
         n_l += int'(bus.long_pulse[0]);
      end
      checks++;
      if (n_p != 1 || n_r != 1 || n_l != 0) begin
         errors++;
         $display("FAIL short_press: press=%0d release=%0d long=%0d expected 1/1/0", n_p, n_r, n_l);
      end
      settle(12);
   endtask

   task automatic test_autorepeat();
      int times[$];
      int exp_n;
      for (int k = 0; k < 75; k++) begin
         bus.pb_in[3] = (k < 60);
         @(negedge clk);
         checks++;
         if (dut_vec !== mod_vec) begin
            errors++;
            $display("FAIL repeat_model t=%0d: dut=%h model=%h", k + 1, dut_vec, mod_vec);
         end
         if (bus.press_pulse[3]) times.push_back(k + 1);
      end
`ifdef PB_AUTOREPEAT_EN
      exp_n = 5;  // offsets 0, 28, 36, 44, 52 fit before the release at 66
`else
      exp_n = 1;
`endif
      checks++;
      if (times.size() != exp_n) begin
         errors++;
         $display("FAIL repeat_count: got=%0d expected=%0d", times.size(), exp_n);
      end
      for (int i = 1; i < times.size(); i++) begin
         checks++;
         if (times[i] - times[0] != LONG + REP * i) begin
            errors++;
            $display("FAIL repeat_offset[%0d]: got=%0d expected=%0d", i, times[i] - times[0], LONG + REP * i);
         end
      end
      settle(12);
   endtask

   task automatic test_reset_mid_hold();
      int t_p = -1, n_r = 0;
      bus.pb_in[0] = 1'b1;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dut_vec !== '0) begin
         errors++;
         $display("FAIL reset_async: dut=%h expected=0", dut_vec);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== mod_vec) begin
            errors++;
            $display("FAIL reset_hold_model t=%0d: dut=%h model=%h", k + 1, dut_vec, mod_vec);
         end
         if (bus.press_pulse[0] && t_p < 0) t_p = k + 1;
         n_r += int'(bus.release_pulse[0]);
      end
      checks++;
      if (t_p != 2 + DEB || n_r != 0) begin
         errors++;
         $display("FAIL reset_hold: press at=%0d releases=%0d expected %0d, 0", t_p, n_r, 2 + DEB);
      end
      settle(12);
   endtask

   task automatic test_random();
      int remain [N];
      for (int c = 0; c < N; c++) remain[c] = 0;
      for (int k = 0; k < 1500; k++) begin
         for (int c = 0; c < N; c++) begin
            if (remain[c] == 0) begin
               bus.pb_in[c] = 1'($urandom_range(0, 1));
               remain[c]    = int'($urandom_range(1, 45));
            end
            remain[c]--;
         end
         @(negedge clk);
         checks++;
         if (dut_vec !== mod_vec) begin
            errors++;
            $display("FAIL random_model k=%0d: dut=%h model=%h", k, dut_vec, mod_vec);
         end
      end
      settle(12);
   endtask

   initial begin
      bus.pb_in = '0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_press();
      test_short_press();
      test_autorepeat();
      test_reset_mid_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
